// File: rtl/trig_capture_pkg.sv
// Shared types for the triggered two-channel capture buffer.
// Holds the capture FSM state encoding and the channel count used to pack RAM words.
package trig_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    localparam int NUM_CH = 2;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The array itself is never reset; only the read-data register is cleared.
module capture_ram #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Both ports update on the same edge, so a same-address read sees the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/trig_capture.sv
// Triggered capture of the sine generator's two channels: waits for a rising
// crossing of channel 1 through trig_level, then stores a 2^ADDR_WIDTH window.
module trig_capture
    import trig_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic [DATA_WIDTH-1:0] din2,
    input  logic                  arm,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    output logic                  armed,
    output logic                  capturing,
    output logic                  done
);

    localparam int                    WORD_WIDTH = NUM_CH * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
    localparam logic [ADDR_WIDTH-1:0] FIRST_NEXT = ADDR_WIDTH'(1);

    cap_state_t            state_reg;
    logic [DATA_WIDTH-1:0] prev_reg;
    logic                  prev_valid_reg;
    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic                  armed_reg;
    logic                  capturing_reg;
    logic                  done_reg;

    logic                  trigger;
    logic                  we;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WORD_WIDTH-1:0] wr_word;
    logic [WORD_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] ch_in  [NUM_CH];
    logic [DATA_WIDTH-1:0] ch_out [NUM_CH];

    assign ch_in[0] = din1;
    assign ch_in[1] = din2;

    // Channel i occupies slice i of the RAM word, so the word reads {din2, din1}.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
            assign wr_word[gi*DATA_WIDTH +: DATA_WIDTH] = ch_in[gi];
            assign ch_out[gi] = rd_word[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign rd_data1 = ch_out[0];
    assign rd_data2 = ch_out[1];

    // Rising crossing needs a valid previous sample, so the first one after arming can't fire.
    assign trigger = (state_reg == ARMED) && en && prev_valid_reg &&
                     (prev_reg < trig_level) && (din1 >= trig_level);

    assign we      = trigger || ((state_reg == CAPTURE) && en);
    assign wr_addr = trigger ? '0 : wr_ptr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            prev_reg       <= '0;
            prev_valid_reg <= 1'b0;
            wr_ptr_reg     <= '0;
            armed_reg      <= 1'b0;
            capturing_reg  <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (arm) begin
                        state_reg      <= ARMED;
                        prev_valid_reg <= 1'b0;
                        armed_reg      <= 1'b1;
                        capturing_reg  <= 1'b0;
                        done_reg       <= 1'b0;
                    end
                end
                ARMED: begin
                    if (en) begin
                        prev_reg       <= din1;
                        prev_valid_reg <= 1'b1;
                        if (trigger) begin
                            state_reg     <= CAPTURE;
                            wr_ptr_reg    <= FIRST_NEXT;
                            armed_reg     <= 1'b0;
                            capturing_reg <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (en) begin
                        // Pointer wraps to zero on the last write, ready for the next capture.
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                        if (wr_ptr_reg == LAST_ADDR) begin
                            state_reg     <= DONE;
                            capturing_reg <= 1'b0;
                            done_reg      <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    armed_reg     <= 1'b0;
                    capturing_reg <= 1'b0;
                    done_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign armed     = armed_reg;
    assign capturing = capturing_reg;
    assign done      = done_reg;

    capture_ram #(
        .WIDTH      (WORD_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_word),
        .rd_addr (rd_addr),
        .rd_data (rd_word)
    );

endmodule
